vram_slot_arbiter: RTL

// - Time-slot arbiter sharing one tilemap VRAM between the 68000 CPU port and the video fetch pipeline.
// - Slot = {ABS_4H,ABS_2H,ABS_1H} from the video timing generator (8 pixel slots per character).
// - Video owns the masked slots on visible lines; the CPU owns the rest, and every slot during VBLANK.
// - Generates RAM address, data and write strobes, the video data latch, and the CPU DTACK handshake.

---
 rtl/vram_arb_pkg.sv | 23 ++
 rtl/vram_cpu_port.sv | 118 +++++++++++
 rtl/vram_slot_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM slot arbiter: CPU port states, slot width, ownership decode.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
package vram_arb_pkg;

  localparam int SLOT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACC,
    RDLAT,
    ACK
  } cpu_state_t;

  // Video owns a slot only on visible lines and only where its mask bit is set.
  function automatic logic slot_is_video(input logic [SLOT_W-1:0] slot,
                                         input logic              vblank_n,
                                         input logic [7:0]        mask);
    return vblank_n & mask[slot];
  endfunction

endpackage

// File: rtl/vram_cpu_port.sv
// 68000-side VRAM port: request capture, slot wait, single-slot access, readback and DTACK handshake.
// Latency: access 1-2 enables after CS_n is seen (next CPU slot); DTACK_n low 2 enables after the access slot.
// Backpressure: the CPU is held by DTACK_n until its access completes; no new cycle is accepted until CS_n rises.
module vram_cpu_port
  import vram_arb_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cpu_slot,
  input  logic          cs_n,
  input  logic          rw,
  input  logic          uds_n,
  input  logic          lds_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] ram_dout,
  output logic          acc_start,
  output logic [AW-1:0] acc_addr,
  output logic [DW-1:0] acc_din,
  output logic [1:0]    acc_we_n,
  output logic [DW-1:0] dout,
  output logic          dtack_n
);

  cpu_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          rw_q, rw_d;
  logic [1:0]    strb_q, strb_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dtack_n_q, dtack_n_d;

  // Bus-cycle sequencing; every transition, including the DTACK release, waits for a pixel enable.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rw_d      = rw_q;
    strb_d    = strb_q;
    dout_d    = dout_q;
    dtack_n_d = dtack_n_q;
    acc_start = 1'b0;
    if (cen) begin
      case (state_q)
        IDLE: begin
          if (!cs_n) begin
            state_d = PEND;
            addr_d  = addr;
            din_d   = din;
            rw_d    = rw;
            strb_d  = {uds_n, lds_n};
          end
        end
        PEND: begin
          // An abort wins over a CPU slot arriving at the same enable.
          if (cs_n) begin
            state_d = IDLE;
          end else if (cpu_slot) begin
            state_d   = ACC;
            acc_start = 1'b1;
          end
        end
        ACC: begin
          state_d = RDLAT;
        end
        RDLAT: begin
          // RAM read data for the access slot is present now; writes pass through for equal timing.
          if (rw_q) begin
            dout_d = ram_dout;
          end
          dtack_n_d = 1'b0;
          state_d   = ACK;
        end
        ACK: begin
          if (cs_n) begin
            dtack_n_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      rw_q      <= 1'b1;
      strb_q    <= 2'b11;
      dout_q    <= '0;
      dtack_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rw_q      <= rw_d;
      strb_q    <= strb_d;
      dout_q    <= dout_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  assign acc_addr = addr_q;
  assign acc_din  = din_q;
  assign acc_we_n = rw_q ? 2'b11 : strb_q;
  assign dout     = dout_q;
  assign dtack_n  = dtack_n_q;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one tilemap VRAM between the 68000 CPU port and the video fetch pipeline.
// Latency: RAM drive registered at the slot's enable; video data 2 enables after slot start; CPU DTACK 2 enables after its slot.
// Backpressure: video never waits; the CPU is stalled through DTACK_n until a CPU-owned slot serves it.
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int         AW            = 12,
  parameter int         DW            = 16,
  parameter logic [7:0] VID_SLOT_MASK = 8'h55
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_MRST_n,
  input  logic          i_EMU_CLK6MPCEN_n,
  input  logic          i_ABS_4H,
  input  logic          i_ABS_2H,
  input  logic          i_ABS_1H,
  input  logic          i_VBLANK_n,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [DW-1:0] o_VID_DATA,
  output logic          o_VID_VALID,
  input  logic          i_CPU_CS_n,
  input  logic          i_CPU_RW,
  input  logic          i_CPU_UDS_n,
  input  logic          i_CPU_LDS_n,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_DTACK_n,
  output logic [AW-1:0] o_RAM_ADDR,
  output logic [DW-1:0] o_RAM_DIN,
  output logic [1:0]    o_RAM_WE_n,
  input  logic [DW-1:0] i_RAM_DOUT
);

  logic              cen;
  logic [SLOT_W-1:0] slot;
  logic              vid_own;

  logic              cpu_acc_start;
  logic [AW-1:0]     cpu_acc_addr;
  logic [DW-1:0]     cpu_acc_din;
  logic [1:0]        cpu_acc_we_n;

  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_din_q, ram_din_d;
  logic [1:0]        ram_we_n_q, ram_we_n_d;
  logic              vid_slot_q, vid_slot_d;   // previous slot was a video read
  logic              vid_wait_q, vid_wait_d;   // RAM output for that read is now present
  logic [DW-1:0]     vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;

  assign cen     = ~i_EMU_CLK6MPCEN_n;
  assign slot    = {i_ABS_4H, i_ABS_2H, i_ABS_1H};
  assign vid_own = slot_is_video(slot, i_VBLANK_n, VID_SLOT_MASK);

  vram_cpu_port #(
    .AW (AW),
    .DW (DW)
  ) u_cpu (
    .clk       (i_EMU_MCLK),
    .rst_n     (i_MRST_n),
    .cen       (cen),
    .cpu_slot  (~vid_own),
    .cs_n      (i_CPU_CS_n),
    .rw        (i_CPU_RW),
    .uds_n     (i_CPU_UDS_n),
    .lds_n     (i_CPU_LDS_n),
    .addr      (i_CPU_ADDR),
    .din       (i_CPU_DIN),
    .ram_dout  (i_RAM_DOUT),
    .acc_start (cpu_acc_start),
    .acc_addr  (cpu_acc_addr),
    .acc_din   (cpu_acc_din),
    .acc_we_n  (cpu_acc_we_n),
    .dout      (o_CPU_DOUT),
    .dtack_n   (o_CPU_DTACK_n)
  );

  // RAM drive mux and two-stage video read pipeline; all of it advances only on pixel enables.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_n_d  = ram_we_n_q;
    vid_slot_d  = vid_slot_q;
    vid_wait_d  = vid_wait_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    if (cen) begin
      vid_slot_d = vid_own;
      vid_wait_d = vid_slot_q;
      // cpu_acc_start is only raised in CPU-owned slots, so video can never be displaced.
      if (cpu_acc_start) begin
        ram_addr_d = cpu_acc_addr;
        ram_din_d  = cpu_acc_din;
        ram_we_n_d = cpu_acc_we_n;
      end else begin
        ram_addr_d = i_VID_ADDR;
        ram_we_n_d = 2'b11;
      end
      if (vid_wait_q) begin
        vid_data_d  = i_RAM_DOUT;
        vid_valid_d = 1'b1;
      end
    end
  end

  // Output and pipeline registers; reset drops the write strobes immediately.
  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_n_q  <= 2'b11;
      vid_slot_q  <= 1'b0;
      vid_wait_q  <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_n_q  <= ram_we_n_d;
      vid_slot_q  <= vid_slot_d;
      vid_wait_q  <= vid_wait_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign o_RAM_ADDR  = ram_addr_q;
  assign o_RAM_DIN   = ram_din_q;
  assign o_RAM_WE_n  = ram_we_n_q;
  assign o_VID_DATA  = vid_data_q;
  assign o_VID_VALID = vid_valid_q;

endmodule
